line_buffer: RTL and testbench
==============================

// Module: line_buffer
// PURPOSE
//  Upstream feeder for the convolution engine. Accepts a raster stream of pixel words
//  (IMAGE_NB pixels per word, row-major) and buffers KERNEL_HEIGHT-1 previous rows.
//  Emits vertically aligned columns of KERNEL_HEIGHT words, the engine's image/image_valid.
//  Handles per-frame priming, so the engine only ever sees complete kernel-height windows.
// PARAMETERS
//  IMAGE_WIDTH    16  bits per pixel
//  IMAGE_NB       8   pixels per word; WORD_WIDTH = IMAGE_WIDTH*IMAGE_NB (localparam)
//  KERNEL_HEIGHT  3   rows per output column (>=2)
//  ROW_WORDS      64  words per image row (>=2)
//  FRAME_ROWS     64  rows per frame (>=KERNEL_HEIGHT)
// PORTS
//  clk       in   1                         clock
//  rst       in   1                         asynchronous, active-high reset
//  up_data   in   WORD_WIDTH                incoming pixel word
//  up_valid  in   1                         up_data valid
//  up_ready  out  1                         word accepted when up_valid & up_ready
//  dn_image  out  KERNEL_HEIGHT*WORD_WIDTH  slice h = row (r-KERNEL_HEIGHT+1+h); h=KH-1 is current
//  dn_valid  out  1                         dn_image valid (drives engine image_valid)
//  dn_ready  in   1                         downstream consumes when dn_valid & dn_ready
//  dn_last   out  1                         qualifies last column of the frame
// BEHAVIOUR
//  - Reset (async assert, sync release): dn_valid=0, dn_last=0, dn_image=0, col=0, row=0,
//    bank pointer=0, state=PRIME. up_ready is a combinational output, so after reset it is 1.
//  - Reset mid-frame discards the partial frame. RAM contents are not cleared; they are
//    never output before being rewritten in the next PRIME.
//  - up_ready = !dn_valid | dn_ready: single output register, no skid. Accept = up_valid & up_ready.
//  - Counters advance on accept only:
//    - col wraps ROW_WORDS-1 -> 0 and increments row.
//    - row wraps FRAME_ROWS-1 -> 0.
//    - bank pointer (0..KH-2) advances modulo KH-1 on each col wrap.
//  - Storage: KH-1 row banks of ROW_WORDS x WORD_WIDTH.
//    - On accept at column c, every bank is read at c.
//    - up_data is written into the bank at the pointer, which holds the oldest row.
//    - Read-before-write semantics on the written bank.
//  - Latency: a word accepted in cycle N appears as slice KH-1 of dn_image in cycle N+1.
//    - The other slices are the banks' registered reads, ordered oldest->newest from the pointer.
//    - Read registers and the current-word register load only on accept; they hold during stall.
//  - FSM, state_t {PRIME, STREAM}:
//    - PRIME: accepts words but produces no dn_valid.
//      -> STREAM on accept of the last word of row KH-2.
//    - STREAM: dn_valid <= 1 on every accept. dn_valid <= 0 on a dn_ready cycle with no accept.
//      -> PRIME on accept of the last word of row FRAME_ROWS-1.
//  - Output column counts: frame produces (FRAME_ROWS-KH+1)*ROW_WORDS columns.
//    dn_last=1 with the final column of the frame only.
//  - Simultaneous dn_ready & accept while dn_valid=1: dn_valid stays 1 and the data is replaced.
//    This gives full throughput of one word per cycle.
//  - Back-pressure: dn_valid=1 & dn_ready=0 holds dn_image/dn_last stable and drops up_ready.
//  - Width rules: col is $clog2(ROW_WORDS) bits, row is $clog2(FRAME_ROWS) bits.
//    No arithmetic on pixel data.
// STRUCTURE
//  - Package conv_pkg: state_t enum, and a WORD_WIDTH helper function shared with engine.
//  - Sub-module line_ram: simple dual-port ROW_WORDS x WORD_WIDTH, registered read,
//    read-before-write, read enable. Instantiated KH-1 times in a generate loop.
//  - Top level holds the counters, bank-pointer rotation, FSM, output register and handshake.
// TESTING (KH=3, IMAGE_NB=2, IMAGE_WIDTH=16, ROW_WORDS=4, FRAME_ROWS=5; word k = value k)
//  1 Stream words 0..19 with dn_ready=1 -> no dn_valid for words 0..7.
//    Word 8 gives dn_image={8,4,0} (h2,h1,h0) one cycle later. Output sequence ends {19,15,11}.
//    12 columns total, dn_last only with {19,15,11}.
//  2 Frame 1 directly followed by frame 2 (words 20..39) -> PRIME re-entered.
//    First frame-2 output is {28,24,20}. No frame-1 data leaks into frame 2.
//  3 Hold dn_ready=0 for 5 cycles at column {9,5,1} -> dn_image stable, up_ready=0.
//    No words lost. Resume gives {10,6,2} next.
//  4 up_valid toggling 1,0,1,0 -> outputs identical to test 1, with gaps. No duplicates.
//  5 Assert rst after word 13 accepted, then restart at word 0 -> dn_valid=0 during reset.
//    Output follows test 1 exactly.
//  6 Random up_valid/dn_ready over 3 frames -> scoreboard matches a golden row model.
//    Assert dn_valid never rises in PRIME.

Source files
------------

// File: rtl/conv_pkg.sv
// Types and helpers shared by the line buffer and the convolution engine.
package conv_pkg;

    typedef enum logic {
        PRIME  = 1'b0,
        STREAM = 1'b1
    } state_t;

    function automatic int word_width(input int image_width, input int image_nb);
        return image_width * image_nb;
    endfunction

endpackage

// File: rtl/line_ram.sv
// One row bank: simple dual-port memory, registered read-before-write output.
module line_ram #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 128,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Non-blocking read returns the old word when the same address is written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/line_buffer.sv
// Buffers KERNEL_HEIGHT-1 rows and emits vertically aligned columns of words.
// Handshake: a word moves on either side only in a cycle where valid & ready are both 1.
module line_buffer
    import conv_pkg::*;
#(
    parameter int IMAGE_WIDTH   = 16,
    parameter int IMAGE_NB      = 8,
    parameter int KERNEL_HEIGHT = 3,
    parameter int ROW_WORDS     = 64,
    parameter int FRAME_ROWS    = 64,
    localparam int WORD_WIDTH   = word_width(IMAGE_WIDTH, IMAGE_NB)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [WORD_WIDTH-1:0]             up_data,
    input  logic                              up_valid,
    output logic                              up_ready,
    output logic [KERNEL_HEIGHT*WORD_WIDTH-1:0] dn_image,
    output logic                              dn_valid,
    input  logic                              dn_ready,
    output logic                              dn_last,
    output logic                              dbg_stream
);

    localparam int NB  = KERNEL_HEIGHT - 1;
    localparam int CW  = $clog2(ROW_WORDS);
    localparam int RWW = $clog2(FRAME_ROWS);
    localparam int PW  = (NB > 1) ? $clog2(NB) : 1;

    state_t                  state;
    logic [CW-1:0]           col;
    logic [RWW-1:0]          row;
    logic [PW-1:0]           ptr;
    logic [PW-1:0]           rd_ptr;
    logic [WORD_WIDTH-1:0]   cur_q;
    logic [WORD_WIDTH-1:0]   bank_q [NB];
    logic                    accept;
    logic                    col_last;
    logic                    row_last;

    assign up_ready   = !dn_valid || dn_ready;
    assign accept     = up_valid && up_ready;
    assign col_last   = (col == CW'(ROW_WORDS - 1));
    assign row_last   = (row == RWW'(FRAME_ROWS - 1));
    assign dbg_stream = (state == STREAM);

    function automatic logic [PW-1:0] rot(input logic [PW-1:0] p, input int h);
        int s;
        s = int'(p) + h;
        if (s >= NB) s = s - NB;
        return PW'(s);
    endfunction

    for (genvar b = 0; b < NB; b++) begin : g_bank
        line_ram #(
            .DEPTH (ROW_WORDS),
            .WIDTH (WORD_WIDTH)
        ) u_ram (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (accept && (ptr == PW'(b))),
            .wr_addr (col),
            .wr_data (up_data),
            .rd_en   (accept),
            .rd_addr (col),
            .rd_data (bank_q[b])
        );
    end

    // The bank at rd_ptr held the oldest row when the column was read.
    always_comb begin
        dn_image = '0;
        for (int h = 0; h < NB; h++) begin
            dn_image[h*WORD_WIDTH +: WORD_WIDTH] = bank_q[rot(rd_ptr, h)];
        end
        dn_image[NB*WORD_WIDTH +: WORD_WIDTH] = cur_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= PRIME;
            col      <= '0;
            row      <= '0;
            ptr      <= '0;
            rd_ptr   <= '0;
            cur_q    <= '0;
            dn_valid <= 1'b0;
            dn_last  <= 1'b0;
        end else begin
            if (accept) begin
                cur_q  <= up_data;
                rd_ptr <= ptr;
                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + 1'b1;
                    ptr <= (ptr == PW'(NB - 1)) ? '0 : ptr + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
            case (state)
                PRIME: begin
                    if (dn_ready) begin
                        dn_valid <= 1'b0;
                        dn_last  <= 1'b0;
                    end
                    if (accept && col_last && row == RWW'(NB - 1)) begin
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        dn_valid <= 1'b1;
                        dn_last  <= col_last && row_last;
                        if (col_last && row_last) begin
                            state <= PRIME;
                        end
                    end else if (dn_ready) begin
                        dn_valid <= 1'b0;
                        dn_last  <= 1'b0;
                    end
                end
                default: state <= PRIME;
            endcase
        end
    end

endmodule

// File: tb/tb_line_buffer.sv
// Bench for line_buffer: scenario tasks checked against a row-array reference model.
module tb_line_buffer;

    localparam int IW  = 16;
    localparam int NBP = 2;
    localparam int KH  = 3;
    localparam int RW  = 4;
    localparam int FR  = 5;
    localparam int W   = IW * NBP;
    localparam int IMG = KH * W;
    localparam int EW  = IMG + 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [W-1:0]   up_data;
    logic           up_valid;
    logic           up_ready;
    logic [IMG-1:0] dn_image;
    logic           dn_valid;
    logic           dn_ready;
    logic           dn_last;
    logic           dbg_stream;

    int n_tests = 0;
    int n_fail  = 0;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] seq1[$];
    logic [W-1:0]  fr [FR][RW];
    int            m_row;
    int            m_col;

    always #5 clk = ~clk;

    line_buffer #(
        .IMAGE_WIDTH   (IW),
        .IMAGE_NB      (NBP),
        .KERNEL_HEIGHT (KH),
        .ROW_WORDS     (RW),
        .FRAME_ROWS    (FR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .up_data    (up_data),
        .up_valid   (up_valid),
        .up_ready   (up_ready),
        .dn_image   (dn_image),
        .dn_valid   (dn_valid),
        .dn_ready   (dn_ready),
        .dn_last    (dn_last),
        .dbg_stream (dbg_stream)
    );

    // Reference model: the frame as a 2-D array; each accepted word from row KH-1 on
    // yields the column of that word and the KH-1 rows above it.
    task automatic model_reset();
        exp_q.delete();
        m_row = 0;
        m_col = 0;
    endtask

    task automatic model_accept(input logic [W-1:0] d);
        logic [EW-1:0] e;
        fr[m_row][m_col] = d;
        if (m_row >= KH - 1) begin
            e = '0;
            for (int h = 0; h < KH; h++) e[h*W +: W] = fr[m_row-KH+1+h][m_col];
            e[EW-1] = (m_row == FR - 1) && (m_col == RW - 1);
            exp_q.push_back(e);
        end
        m_col++;
        if (m_col == RW) begin
            m_col = 0;
            m_row = (m_row + 1) % FR;
        end
    endtask

    // Column built from word index k when word k equals value k.
    function automatic logic [EW-1:0] img_of(input int k, input logic l);
        logic [EW-1:0] e;
        e = '0;
        e[EW-1] = l;
        for (int h = 0; h < KH; h++) e[h*W +: W] = W'(k - (KH - 1 - h) * RW);
        return e;
    endfunction

    // Drive one cycle from a negedge; report accept/consume and the popped expectation.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic r,
                         output logic acc, output logic cons, output logic he,
                         output logic [EW-1:0] e, output logic [EW-1:0] a);
        up_valid = v;
        up_data  = d;
        dn_ready = r;
        #1;
        acc  = up_valid && up_ready;
        cons = dn_valid && dn_ready;
        a    = {dn_last, dn_image};
        he   = exp_q.size() > 0;
        e    = '0;
        if (cons && he) e = exp_q.pop_front();
        if (acc) model_accept(d);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; up_valid = 1'b0; up_data = '0; dn_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_tests += 5;
        if (dn_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", dn_valid); end
        if (dn_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", dn_last); end
        if (dn_image !== '0) begin n_fail++; $display("FAIL reset_image: got %h want 0", dn_image); end
        if (up_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", up_ready); end
        if (dbg_stream !== 1'b0) begin n_fail++; $display("FAIL reset_state: got %b want PRIME", dbg_stream); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_stream();
        logic acc, cons, he; logic [EW-1:0] e, a;
        int k = 0; int lasts = 0; logic early = 1'b0;
        seq1.delete();
        for (int cyc = 0; cyc < 200 && (k < 20 || exp_q.size() > 0 || dn_valid); cyc++) begin
            cycle(k < 20, W'(k), 1'b1, acc, cons, he, e, a);
            if (cons) begin
                n_tests++;
                if (!he || a !== e) begin n_fail++; $display("FAIL stream_col: got %h want %h", a, e); end
                if (k < 9) early = 1'b1;
                if (a[EW-1]) lasts++;
                seq1.push_back(a);
            end
            if (acc) k++;
        end
        n_tests += 6;
        if (k != 20) begin n_fail++; $display("FAIL stream_accepted: got %0d want 20", k); end
        if (early) begin n_fail++; $display("FAIL stream_prime: got output before word 8 want none"); end
        if (seq1.size() != 12) begin n_fail++; $display("FAIL stream_count: got %0d want 12", seq1.size()); end
        if (lasts != 1) begin n_fail++; $display("FAIL stream_lasts: got %0d want 1", lasts); end
        if (seq1.size() == 0 || seq1[0] !== img_of(8, 1'b0)) begin
            n_fail++; $display("FAIL stream_first: got %h want %h", (seq1.size() > 0) ? seq1[0] : '0, img_of(8, 1'b0));
        end
        if (seq1.size() == 0 || seq1[seq1.size()-1] !== img_of(19, 1'b1)) begin
            n_fail++; $display("FAIL stream_final: got %h want %h", (seq1.size() > 0) ? seq1[seq1.size()-1] : '0, img_of(19, 1'b1));
        end
    endtask

    task automatic test_back_to_back();
        logic acc, cons, he; logic [EW-1:0] e, a;
        int k = 0; int cols = 0; int lasts = 0; logic [EW-1:0] thirteenth = '0;
        for (int cyc = 0; cyc < 300 && (k < 40 || exp_q.size() > 0 || dn_valid); cyc++) begin
            cycle(k < 40, W'(k), 1'b1, acc, cons, he, e, a);
            if (cons) begin
                n_tests++;
                if (!he || a !== e) begin n_fail++; $display("FAIL b2b_col: got %h want %h", a, e); end
                cols++;
                if (cols == 13) thirteenth = a;
                if (a[EW-1]) lasts++;
            end
            if (acc) k++;
        end
        n_tests += 3;
        if (cols != 24) begin n_fail++; $display("FAIL b2b_count: got %0d want 24", cols); end
        if (lasts != 2) begin n_fail++; $display("FAIL b2b_lasts: got %0d want 2", lasts); end
        if (thirteenth !== img_of(28, 1'b0)) begin n_fail++; $display("FAIL b2b_frame2_first: got %h want %h", thirteenth, img_of(28, 1'b0)); end
    endtask

    task automatic test_backpressure();
        logic acc, cons, he; logic [EW-1:0] e, a;
        int k = 0; logic stalled = 1'b0; logic after9 = 1'b0;
        for (int cyc = 0; cyc < 200 && (k < 20 || exp_q.size() > 0 || dn_valid); cyc++) begin
            if (!stalled && dn_valid && {dn_last, dn_image} === img_of(9, 1'b0)) begin
                for (int i = 0; i < 5; i++) begin
                    cycle(1'b1, W'(k), 1'b0, acc, cons, he, e, a);
                    n_tests += 2;
                    if (acc) begin n_fail++; $display("FAIL bp_ready: got accept want up_ready=0"); end
                    if (a !== img_of(9, 1'b0)) begin n_fail++; $display("FAIL bp_hold: got %h want %h", a, img_of(9, 1'b0)); end
                end
                stalled = 1'b1;
            end
            cycle(k < 20, W'(k), 1'b1, acc, cons, he, e, a);
            if (cons) begin
                n_tests++;
                if (!he || a !== e) begin n_fail++; $display("FAIL bp_col: got %h want %h", a, e); end
                if (after9) begin
                    n_tests++;
                    if (a !== img_of(10, 1'b0)) begin n_fail++; $display("FAIL bp_resume: got %h want %h", a, img_of(10, 1'b0)); end
                end
                after9 = stalled && (a === img_of(9, 1'b0));
            end
            if (acc) k++;
        end
        n_tests += 2;
        if (!stalled) begin n_fail++; $display("FAIL bp_reached: got no column {9,5,1} want one"); end
        if (k != 20) begin n_fail++; $display("FAIL bp_accepted: got %0d want 20", k); end
    endtask

    task automatic test_toggle();
        logic acc, cons, he; logic [EW-1:0] e, a;
        int k = 0; logic [EW-1:0] seq[$];
        for (int cyc = 0; cyc < 300 && (k < 20 || exp_q.size() > 0 || dn_valid); cyc++) begin
            cycle((k < 20) && (cyc % 2 == 0), W'(k), 1'b1, acc, cons, he, e, a);
            if (cons) begin
                n_tests++;
                if (!he || a !== e) begin n_fail++; $display("FAIL toggle_col: got %h want %h", a, e); end
                seq.push_back(a);
            end
            if (acc) k++;
        end
        n_tests++;
        if (seq.size() != seq1.size()) begin n_fail++; $display("FAIL toggle_count: got %0d want %0d", seq.size(), seq1.size()); end
        for (int i = 0; i < seq.size() && i < seq1.size(); i++) begin
            n_tests++;
            if (seq[i] !== seq1[i]) begin n_fail++; $display("FAIL toggle_seq[%0d]: got %h want %h", i, seq[i], seq1[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic acc, cons, he; logic [EW-1:0] e, a;
        int k = 0; logic [EW-1:0] seq[$];
        for (int cyc = 0; cyc < 100 && k < 14; cyc++) begin
            cycle(1'b1, W'(k), 1'b1, acc, cons, he, e, a);
            if (cons) begin
                n_tests++;
                if (!he || a !== e) begin n_fail++; $display("FAIL rstmid_pre_col: got %h want %h", a, e); end
            end
            if (acc) k++;
        end
        rst = 1'b1; up_valid = 1'b0; dn_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_tests += 2;
            if (dn_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", dn_valid); end
            if (dn_image !== '0) begin n_fail++; $display("FAIL rstmid_image: got %h want 0", dn_image); end
            @(negedge clk);
        end
        rst = 1'b0;
        model_reset();
        k = 0;
        for (int cyc = 0; cyc < 200 && (k < 20 || exp_q.size() > 0 || dn_valid); cyc++) begin
            cycle(k < 20, W'(k), 1'b1, acc, cons, he, e, a);
            if (cons) begin
                n_tests++;
                if (!he || a !== e) begin n_fail++; $display("FAIL rstmid_col: got %h want %h", a, e); end
                seq.push_back(a);
            end
            if (acc) k++;
        end
        n_tests++;
        if (seq.size() != seq1.size()) begin n_fail++; $display("FAIL rstmid_count: got %0d want %0d", seq.size(), seq1.size()); end
        for (int i = 0; i < seq.size() && i < seq1.size(); i++) begin
            n_tests++;
            if (seq[i] !== seq1[i]) begin n_fail++; $display("FAIL rstmid_seq[%0d]: got %h want %h", i, seq[i], seq1[i]); end
        end
    endtask

    task automatic test_random();
        logic acc, cons, he, v, r; logic [EW-1:0] e, a, prev_a;
        int k = 0; int cols = 0;
        logic pv = 1'b0; logic ps = 1'b0; logic hold = 1'b0;
        prev_a = '0;
        for (int cyc = 0; cyc < 3000 && (k < 3 * FR * RW || exp_q.size() > 0 || dn_valid); cyc++) begin
            if (!pv && dn_valid) begin
                n_tests++;
                if (!ps) begin n_fail++; $display("FAIL rand_prime_rise: got dn_valid rise from PRIME want none"); end
            end
            pv = dn_valid;
            ps = dbg_stream;
            v  = (k < 3 * FR * RW) && ($urandom_range(0, 3) != 0);
            r  = $urandom_range(0, 3) != 0;
            cycle(v, W'($urandom), r, acc, cons, he, e, a);
            if (hold) begin
                n_tests++;
                if (a !== prev_a) begin n_fail++; $display("FAIL rand_stall: got %h want %h", a, prev_a); end
            end
            hold   = pv && !r;
            prev_a = a;
            if (cons) begin
                n_tests++;
                if (!he || a !== e) begin n_fail++; $display("FAIL rand_col: got %h want %h", a, e); end
                cols++;
            end
            if (acc) k++;
        end
        n_tests += 2;
        if (k != 3 * FR * RW) begin n_fail++; $display("FAIL rand_accepted: got %0d want %0d", k, 3 * FR * RW); end
        if (cols != 3 * (FR - KH + 1) * RW) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", cols, 3 * (FR - KH + 1) * RW); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_back_to_back();
        test_backpressure();
        test_toggle();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want finish before 500000");
        $fatal(1, "watchdog expired");
    end

endmodule
